// File: rtl/div_ctrl.sv
// Multi-cycle RV32M divide sequencer (DIV/DIVU/REM/REMU) using a radix-2 restoring loop.
// It holds the EX stage via stall_req_o until the result is ready. A flush aborts the divide.
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             annul_i,
    output logic             busy_o,
    output logic             stall_req_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DZERO = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             rem_sel_q, rem_sel_d;
    logic             sgn_q, sgn_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;

    // Operand magnitudes. The most negative value maps onto itself, which is the correct unsigned magnitude.
    logic             in_signed, in_sa, in_sb;
    logic [WIDTH-1:0] in_a_abs, in_b_abs;

    assign in_signed = ~op_i[0];
    assign in_sa     = in_signed & dividend_i[WIDTH-1];
    assign in_sb     = in_signed & divisor_i[WIDTH-1];
    assign in_a_abs  = in_sa ? (~dividend_i + 1'b1) : dividend_i;
    assign in_b_abs  = in_sb ? (~divisor_i + 1'b1) : divisor_i;

    // The compare is WIDTH+1 bits wide. The difference fits in WIDTH bits whenever the subtraction is taken.
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_diff;
    logic [WIDTH-1:0] q_corr, r_corr, res_corr;

    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign rem_ge    = rem_shift >= {1'b0, divisor_q};
    assign rem_diff  = rem_shift[WIDTH-1:0] - divisor_q;
    assign q_corr    = (sgn_q & qneg_q & ~dz_q) ? (~quo_q + 1'b1) : quo_q;
    assign r_corr    = (sgn_q & rneg_q & ~dz_q) ? (~rem_q + 1'b1) : rem_q;
    assign res_corr  = rem_sel_q ? r_corr : q_corr;

    always_comb begin
        state_d   = state_q;
        rem_sel_d = rem_sel_q;
        sgn_d     = sgn_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        dz_d      = dz_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        ready_o   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!annul_i && start_i) begin
                    rem_sel_d = op_i[1];
                    sgn_d     = in_signed;
                    qneg_d    = in_sa ^ in_sb;
                    rneg_d    = in_sa;
                    divisor_d = in_b_abs;
                    cnt_d     = '0;
                    if (divisor_i == '0) begin
                        // RISC-V divide-by-zero: quotient all ones, remainder is the raw dividend
                        dz_d    = 1'b1;
                        quo_d   = '1;
                        rem_d   = dividend_i;
                        state_d = DZERO;
                    end else begin
                        dz_d    = 1'b0;
                        quo_d   = in_a_abs;
                        rem_d   = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (annul_i) begin
                    state_d = IDLE;
                end else begin
                    if (rem_ge) begin
                        rem_d = rem_diff;
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = rem_shift[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DZERO: begin
                state_d = annul_i ? IDLE : DONE;
            end
            DONE: begin
                state_d = IDLE;
                if (!annul_i) begin
                    ready_o  = 1'b1;
                    result_d = res_corr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rem_sel_q <= 1'b0;
            sgn_q     <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            dz_q      <= 1'b0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            rem_sel_q <= rem_sel_d;
            sgn_q     <= sgn_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            dz_q      <= dz_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    // The result is presented in the DONE cycle itself and is then held until the next completion.
    assign result_o    = ready_o ? res_corr : result_q;
    assign busy_o      = (state_q != IDLE);
    assign stall_req_o = start_i & ~ready_o & ~annul_i;

endmodule
